// File: rtl/dpd_acc.sv
// rtl/dpd_acc.sv - digital phase detector: reference accumulator vs sampled DCO phase
// Two-stage pipeline: raw 29-bit error, then 20-bit saturation plus lock tracking.
module dpd_acc #(
  parameter int          LOCK_CNT = 16,
  parameter logic [19:0] LOCK_THR = 20'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ref_tick,
  input  logic [19:0] fcw,
  input  logic [10:0] tdc_frac,
  output logic [19:0] dpd_out,
  output logic        dpd_valid,
  output logic        dpd_sat,
  output logic        locked
);

  localparam logic [7:0] LOCK_CNT8 = 8'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ALIGN, TRACK} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_align_tick;
  logic        w_track_tick;

  logic [17:0] r_v;
  logic [28:0] r_r;
  logic [28:0] r_e;
  logic        r_v1;

  logic [19:0] r_out;
  logic        r_valid;
  logic        r_sat;
  logic        r_locked;
  logic [7:0]  r_lock_cnt;

  logic [28:0] w_p;
  logic [28:0] w_r_sum;
  logic [28:0] w_e;
  logic [9:0]  w_hi;
  logic        w_clamp;
  logic [19:0] w_sat_val;
  logic [19:0] w_abs;
  logic        w_in_win;
  logic [7:0]  w_lock_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_align_tick = 1'b0;
    w_track_tick = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = ALIGN;
        ALIGN: begin
          w_align_tick = ref_tick;
          if (ref_tick) w_state_nxt = TRACK;
        end
        TRACK:   w_track_tick = ref_tick;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  assign w_p     = {r_v, tdc_frac};
  assign w_r_sum = r_r + {9'd0, fcw};
  assign w_e     = w_r_sum - w_p;

  // Stage 1: V counter, reference accumulator and raw error register.
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      r_v  <= '0;
      r_r  <= '0;
      r_e  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v  <= (r_state == IDLE) ? 18'd0 : r_v + 18'd1;
      r_v1 <= w_track_tick;
      if (w_align_tick) r_r <= w_p;
      if (w_track_tick) begin
        r_r <= w_r_sum;
        r_e <= w_e;
      end
    end
  end

  // Bits 28..19 all equal means the error already fits in 20-bit signed.
  assign w_hi      = r_e[28:19];
  assign w_clamp   = !((&w_hi) || !(|w_hi));
  assign w_sat_val = !w_clamp ? r_e[19:0] : (r_e[28] ? 20'h80000 : 20'h7FFFF);
  assign w_abs     = w_sat_val[19] ? (~w_sat_val + 20'd1) : w_sat_val;
  assign w_in_win  = (w_abs < LOCK_THR) && !w_clamp;
  assign w_lock_nxt = !w_in_win ? 8'd0 :
                      (r_lock_cnt == LOCK_CNT8) ? r_lock_cnt : r_lock_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_sat      <= 1'b0;
      r_locked   <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_valid <= r_v1;
      r_sat   <= r_v1 && w_clamp;
      if (r_v1) begin
        r_out      <= w_sat_val;
        r_lock_cnt <= w_lock_nxt;
        r_locked   <= (w_lock_nxt == LOCK_CNT8);
      end
    end
  end

  assign dpd_out   = r_out;
  assign dpd_valid = r_valid;
  assign dpd_sat   = r_sat;
  assign locked    = r_locked;

endmodule

// File: tb/tb_dpd_acc.sv
// tb/tb_dpd_acc.sv - directed bench for dpd_acc
// Outputs are sampled 1 time unit after each rising edge.
module tb_dpd_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        ref_tick = 1'b0;
  logic [19:0] fcw = '0;
  logic [10:0] tdc_frac = '0;
  logic [19:0] dpd_out;
  logic        dpd_valid;
  logic        dpd_sat;
  logic        locked;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dpd_acc #(.LOCK_CNT(16), .LOCK_THR(20'd256)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ref_tick  (ref_tick),
    .fcw       (fcw),
    .tdc_frac  (tdc_frac),
    .dpd_out   (dpd_out),
    .dpd_valid (dpd_valid),
    .dpd_sat   (dpd_sat),
    .locked    (locked)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'd0, dpd_valid, dpd_sat, locked, dpd_out};
  endfunction

  // One ref_tick, check the result two edges later, then idle so the next tick lands gap cycles later.
  task automatic tick(input int gap, input logic ev, input logic [19:0] eout,
                      input logic esat, input logic elk, input string tag);
    ref_tick = 1'b1;
    step();
    ref_tick = 1'b0;
    step();
    chk(tag, outs(), {9'd0, ev, esat, elk, eout});
    repeat (gap - 2) step();
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    fcw = 20'h02000;
    for (int i = 0; i < 6; i++) begin
      ref_tick = i[0];
      step();
      chk("reset", outs(), 32'd0);
    end
    ref_tick = 1'b0;
    rst = 1'b1;
    step();

    tick(4, 1'b0, 20'h00000, 1'b0, 1'b0, "align");
    for (int i = 1; i <= 18; i++)
      tick((i == 18) ? 5 : 4, 1'b1, 20'h00000, 1'b0, (i >= 16), $sformatf("match%0d", i));

    ref_tick = 1'b1;
    step();
    ref_tick = 1'b0;
    en = 1'b0;
    step();
    chk("en_drop", outs(), 32'd0);

    ref_tick = 1'b1;
    step();
    ref_tick = 1'b0;
    step();
    step();
    chk("idle_tick", outs(), 32'd0);
    en = 1'b1;
    step();

    tick(5, 1'b0, 20'h00000, 1'b0, 1'b0, "align2");
    tick(5, 1'b1, 20'hFF800, 1'b0, 1'b0, "slip1");
    tick(5, 1'b1, 20'hFF000, 1'b0, 1'b0, "slip2");
    tick(5, 1'b1, 20'hFE800, 1'b0, 1'b0, "slip3");
    chk("hold", outs(), {9'd0, 1'b0, 1'b0, 1'b0, 20'hFE800});

    en = 1'b0;
    step();
    en = 1'b1;
    fcw = 20'hFFFFF;
    step();
    tick(2, 1'b0, 20'h00000, 1'b0, 1'b0, "align3");
    tick(2, 1'b1, 20'h7FFFF, 1'b1, 1'b0, "possat1");
    tick(2, 1'b1, 20'h7FFFF, 1'b1, 1'b0, "possat2");
    step();
    chk("sat_clear", outs(), {9'd0, 1'b0, 1'b0, 1'b0, 20'h7FFFF});

    en = 1'b0;
    step();
    en = 1'b1;
    fcw = 20'h00000;
    step();
    tick(300, 1'b0, 20'h00000, 1'b0, 1'b0, "align4");
    tick(300, 1'b1, 20'h80000, 1'b1, 1'b0, "negsat");

    en = 1'b0;
    step();
    en = 1'b1;
    fcw = 20'h02000;
    step();
    tdc_frac = 11'd0;
    tick(4, 1'b0, 20'h00000, 1'b0, 1'b0, "align5");
    tdc_frac = 11'd100;
    tick(4, 1'b1, 20'hFFF9C, 1'b0, 1'b0, "frac");
    tdc_frac = 11'd0;
    tick(4, 1'b1, 20'h00000, 1'b0, 1'b0, "frac_back");

    en = 1'b0;
    step();
    en = 1'b1;
    fcw = 20'h00800;
    step();
    ref_tick = 1'b1;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("b2b%0d", i), outs(), {9'd0, 1'b1, 1'b0, 1'b0, 20'h00000});
    end
    ref_tick = 1'b0;
    step();
    chk("b2b_last", outs(), {9'd0, 1'b1, 1'b0, 1'b0, 20'h00000});
    step();
    chk("b2b_end", outs(), 32'd0);

    fcw = 20'h00000;
    ref_tick = 1'b1;
    step();
    ref_tick = 1'b0;
    rst = 1'b0;
    step();
    chk("rst_mid", outs(), 32'd0);
    rst = 1'b1;
    step();
    chk("rst_flush", outs(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
